vpp_meter_multi: RTL

//  Parametrised successor to the single-window peak-to-peak detector on the ADS805 sample path.
//  It measures max, min and Vpp over a programmable number of samples per window.
//  It averages Vpp over 2^avg_log2 consecutive windows and runs a start/busy/valid handshake toward the NIOS PIO.

---
 rtl/vpp_meter_multi.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vpp_meter_multi.sv
// Windowed max/min/Vpp meter with 2^avg_log2 window averaging and start/busy/valid handshake.
// Optional stall watchdog enabled by defining VPP_TIMEOUT_EN.
module vpp_meter_multi #(
  parameter int DW           = 12,
  parameter int CNT_W        = 32,
  parameter int AVG_MAX_LOG2 = 4,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [DW-1:0]    din,
  input  logic [CNT_W-1:0] times,
  input  logic [2:0]       avg_log2,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             vpp_valid,
  output logic [DW-1:0]    max_out,
  output logic [DW-1:0]    min_out,
  output logic [DW-1:0]    vpp_out,
  output logic             timeout
);

  localparam int         WCW       = AVG_MAX_LOG2 + 1;
  localparam int         AW        = DW + AVG_MAX_LOG2;
  localparam logic [2:0] AVG_CLAMP = 3'(AVG_MAX_LOG2);

  typedef enum logic [1:0] {IDLE, ACQ, WEND, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] times_l, scnt;
  logic [2:0]       avg_l;
  logic [DW-1:0]    wmax, wmin, gmax, gmin;
  logic [AW-1:0]    acc;
  logic [WCW-1:0]   wcnt;
  logic             last_win, win_full, stall;

  assign last_win = (wcnt + WCW'(1)) == (WCW'(1) << avg_l);
  assign win_full = sample_en && ((scnt + CNT_W'(1)) == times_l);
  assign busy     = (state != IDLE);

`ifdef VPP_TIMEOUT_EN
  logic [31:0] stall_cnt;

  assign stall = (state == ACQ) && !sample_en && (stall_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state != ACQ || sample_en || abort)
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timeout <= 1'b0;
    else if (state == IDLE && start && !abort)
      timeout <= 1'b0;
    else if (stall && !abort)
      timeout <= 1'b1;
  end
`else
  assign stall   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // A sample seeding the next window in WEND completes it at once when times is 1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = ACQ;
      ACQ: begin
        if (win_full)   state_nxt = WEND;
        else if (stall) state_nxt = IDLE;
      end
      WEND: begin
        if (last_win)                                 state_nxt = DONE;
        else if (sample_en && times_l == CNT_W'(1))   state_nxt = WEND;
        else                                          state_nxt = ACQ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      times_l   <= '0;
      avg_l     <= '0;
      scnt      <= '0;
      wmax      <= '0;
      wmin      <= '0;
      gmax      <= '0;
      gmin      <= '0;
      acc       <= '0;
      wcnt      <= '0;
      max_out   <= '0;
      min_out   <= '0;
      vpp_out   <= '0;
      vpp_valid <= 1'b0;
    end else begin
      vpp_valid <= 1'b0;
      if (!abort) begin
        case (state)
          IDLE: if (start) begin
            times_l <= (times == '0) ? CNT_W'(1) : times;
            avg_l   <= (avg_log2 > AVG_CLAMP) ? AVG_CLAMP : avg_log2;
            wmax    <= '0;
            wmin    <= '1;
            scnt    <= '0;
            gmax    <= '0;
            gmin    <= '1;
            acc     <= '0;
            wcnt    <= '0;
          end
          ACQ: if (sample_en) begin
            wmax <= (din > wmax) ? din : wmax;
            wmin <= (din < wmin) ? din : wmin;
            scnt <= scnt + CNT_W'(1);
          end
          WEND: begin
            acc  <= acc + AW'(wmax - wmin);
            gmax <= (wmax > gmax) ? wmax : gmax;
            gmin <= (wmin < gmin) ? wmin : gmin;
            wcnt <= wcnt + WCW'(1);
            if (!last_win) begin
              if (sample_en) begin
                wmax <= din;
                wmin <= din;
                scnt <= CNT_W'(1);
              end else begin
                wmax <= '0;
                wmin <= '1;
                scnt <= '0;
              end
            end
          end
          DONE: begin
            max_out   <= gmax;
            min_out   <= gmin;
            vpp_out   <= DW'(acc >> avg_l);
            vpp_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
